// File: rtl/neopixel_strip_driver.sv
// rtl/neopixel_strip_driver.sv - WS2812 strip serialiser with a byte-writable GRB frame buffer
// Optional NEO_BRIGHTNESS_EN adds a brightness port that scales every transmitted byte.
module neopixel_strip_driver #(
  parameter int NUM_PIXELS = 8,
  parameter int T0H        = 18,
  parameter int T0L        = 40,
  parameter int T1H        = 35,
  parameter int T1L        = 30,
  parameter int LATCH_CYC  = 2500,
  localparam int PIX_W     = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_color,
  input  logic [PIX_W-1:0] pixel_index,
  input  logic [1:0]       color_index,
  input  logic [7:0]       color_level,
  input  logic             send_it,
`ifdef NEO_BRIGHTNESS_EN
  input  logic [7:0]       brightness,
`endif
  output logic             neo_data,
  output logic             ready_to_load,
  output logic             ready_to_send,
  output logic             frame_done
);

  function automatic int max_of(int a, int b);
    return (a > b) ? a : b;
  endfunction

  localparam int NUM_BITS = 24 * NUM_PIXELS;
  localparam int BIT_W    = $clog2(NUM_BITS + 1);
  localparam int T_MAX    = max_of(max_of(max_of(T0H, T0L), max_of(T1H, T1L)), LATCH_CYC);
  localparam int TMR_W    = $clog2(T_MAX + 1);

  localparam logic [TMR_W-1:0] T0H_END   = TMR_W'(T0H - 1);
  localparam logic [TMR_W-1:0] T0L_END   = TMR_W'(T0L - 1);
  localparam logic [TMR_W-1:0] T1H_END   = TMR_W'(T1H - 1);
  localparam logic [TMR_W-1:0] T1L_END   = TMR_W'(T1L - 1);
  localparam logic [TMR_W-1:0] LATCH_END = TMR_W'(LATCH_CYC - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(NUM_BITS - 1);
  localparam logic [PIX_W:0]   PIX_LIMIT = (PIX_W + 1)'(NUM_PIXELS);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       frame_mem [NUM_PIXELS][3];
  logic [TMR_W-1:0] timer;
  logic [BIT_W-1:0] bit_cnt;
  logic [PIX_W-1:0] pix_ptr;
  logic [1:0]       byte_ptr;
  logic [2:0]       bit_ptr;
  logic [7:0]       cur_level;
  logic [7:0]       tx_byte;
  logic             cur_bit;
  logic             timer_done;
  logic             last_bit;
  logic             write_ok;
  logic             send_ok;

  assign ready_to_load = (state == IDLE);
  assign ready_to_send = (state == IDLE);
  assign send_ok       = send_it && (state == IDLE);
  assign write_ok      = load_color && (state == IDLE) &&
                         ({1'b0, pixel_index} < PIX_LIMIT) && (color_index != 2'd3);
  assign last_bit      = (bit_cnt == LAST_BIT);
  assign cur_level     = frame_mem[pix_ptr][byte_ptr];

`ifdef NEO_BRIGHTNESS_EN
  logic [7:0]  bright_q;
  logic [15:0] scaled;

  // Brightness is frozen at the send edge so one frame never mixes two scales.
  always_ff @(posedge clock) begin
    if (reset) begin
      bright_q <= '0;
    end else if (send_ok) begin
      bright_q <= brightness;
    end
  end

  assign scaled  = {8'd0, cur_level} * ({8'd0, bright_q} + 16'd1);
  assign tx_byte = 8'(scaled >> 8);
`else
  assign tx_byte = cur_level;
`endif

  // bit_ptr counts up from 0, so ~bit_ptr walks the byte MSB first.
  assign cur_bit = tx_byte[~bit_ptr];

  always_comb begin
    state_nxt  = state;
    timer_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (send_it) state_nxt = HIGH;
      end
      HIGH: begin
        timer_done = cur_bit ? (timer == T1H_END) : (timer == T0H_END);
        if (timer_done) state_nxt = LOW;
      end
      LOW: begin
        timer_done = cur_bit ? (timer == T1L_END) : (timer == T0L_END);
        if (timer_done) state_nxt = last_bit ? LATCH : HIGH;
      end
      LATCH: begin
        timer_done = (timer == LATCH_END);
        if (timer_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      neo_data   <= 1'b0;
      frame_done <= 1'b0;
      timer      <= '0;
      bit_cnt    <= '0;
      pix_ptr    <= '0;
      byte_ptr   <= '0;
      bit_ptr    <= '0;
      for (int p = 0; p < NUM_PIXELS; p++) begin
        for (int c = 0; c < 3; c++) begin
          frame_mem[p][c] <= '0;
        end
      end
    end else begin
      state      <= state_nxt;
      neo_data   <= (state_nxt == HIGH);
      frame_done <= (state == LATCH) && timer_done;
      timer      <= (timer_done || state == IDLE) ? '0 : timer + 1'b1;

      if (write_ok) begin
        frame_mem[pixel_index][color_index] <= color_level;
      end

      // Pointers advance only between bits, so the last bit leaves them in range.
      if (state == IDLE) begin
        bit_cnt  <= '0;
        pix_ptr  <= '0;
        byte_ptr <= '0;
        bit_ptr  <= '0;
      end else if (state == LOW && timer_done && !last_bit) begin
        bit_cnt <= bit_cnt + 1'b1;
        bit_ptr <= bit_ptr + 1'b1;
        if (bit_ptr == 3'd7) begin
          if (byte_ptr == 2'd2) begin
            byte_ptr <= '0;
            pix_ptr  <= pix_ptr + 1'b1;
          end else begin
            byte_ptr <= byte_ptr + 1'b1;
          end
        end
      end
    end
  end

endmodule
